led_flow_ctrl: RTL and testbench

- Downstream LED pattern stage. It consumes a single-cycle timebase tick from the 0.5 s counter stage and drives a 4-LED pattern.
- A debounced push-button cycles the pattern mode.
- Sits between the timebase counter and the board LED pins.

---
 rtl/led_pkg.sv | 21 ++
 rtl/led_flow_ctrl_key_filter.sv | 45 ++++
 rtl/led_flow_ctrl.sv | 99 +++++++++
 tb/tb_led_flow_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared encodings and seed patterns for the LED pattern stage.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_FLOW_L = 2'd0,
    MODE_FLOW_R = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  localparam logic [3:0] SEED_L   = 4'b0001;
  localparam logic [3:0] SEED_R   = 4'b1000;
  localparam logic [3:0] SEED_ALL = 4'b1111;

  function automatic mode_e mode_after(input mode_e cur);
    logic [1:0] nxt;
    nxt = cur + 2'd1;
    return mode_e'(nxt);
  endfunction

endpackage

// File: rtl/led_flow_ctrl_key_filter.sv
// Push-button path: 2-flop synchroniser, stability debounce, one-cycle press pulse.
module key_filter #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic Clk50M,
  input  logic Rst_n,
  input  logic key_n,
  output logic key_flag
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             key_s1;
  logic             key_s2;
  logic             key_stable;
  logic             key_stable_d;
  logic [CNT_W-1:0] deb_cnt;

  always_ff @(posedge Clk50M or negedge Rst_n) begin
    if (!Rst_n) begin
      key_s1       <= 1'b1;
      key_s2       <= 1'b1;
      key_stable   <= 1'b1;
      key_stable_d <= 1'b1;
      deb_cnt      <= '0;
      key_flag     <= 1'b0;
    end else begin
      key_s1       <= key_n;
      key_s2       <= key_s1;
      key_stable_d <= key_stable;
      // Press pulse is registered off the stable level, one cycle after it falls.
      key_flag     <= key_stable_d & ~key_stable;
      if (key_s2 == key_stable) begin
        deb_cnt <= '0;
      end else if (deb_cnt == CNT_LAST) begin
        key_stable <= key_s2;
        deb_cnt    <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_flow_ctrl.sv
// 4-LED pattern stage: key-driven mode FSM plus tick-driven pattern update.
// Build option INT_TICK_EN replaces the tick port with an internal TICK_CYC timebase.
//
// state   | meaning
// FLOW_L  | rotate lit LED left on each tick
// FLOW_R  | rotate lit LED right on each tick
// BLINK   | invert all LEDs on each tick
// HOLD    | freeze the current pattern
module led_flow_ctrl
  import led_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int TICK_CYC     = 25_000_000,
  parameter int LED_W        = 4
) (
  input  logic             Clk50M,
  input  logic             Rst_n,
  input  logic             tick,
  input  logic             key_n,
  output logic [LED_W-1:0] led,
  output logic [1:0]       mode,
  output logic             key_flag
);

  if (LED_W != 4 || TICK_CYC < 2) begin : g_param_check
    $error("led_flow_ctrl: LED_W must be 4 and TICK_CYC at least 2");
  end

  mode_e            mode_q;
  mode_e            mode_d;
  logic [LED_W-1:0] led_d;
  logic             tick_int;

  key_filter #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_key_filter (
    .Clk50M  (Clk50M),
    .Rst_n   (Rst_n),
    .key_n   (key_n),
    .key_flag(key_flag)
  );

`ifdef INT_TICK_EN
  localparam int TCNT_W = $clog2(TICK_CYC);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TICK_CYC - 1);

  logic [TCNT_W-1:0] tick_cnt;

  // Free-running: only reset clears it, mode changes leave the phase alone.
  always_ff @(posedge Clk50M or negedge Rst_n) begin
    if (!Rst_n) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TCNT_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick_int = (tick_cnt == TCNT_LAST);
`else
  assign tick_int = tick;
`endif

  always_ff @(posedge Clk50M or negedge Rst_n) begin
    if (!Rst_n) begin
      mode_q <= MODE_FLOW_L;
      led    <= SEED_L;
    end else begin
      mode_q <= mode_d;
      led    <= led_d;
    end
  end

  // A key press outranks a coincident tick; that tick is dropped.
  always_comb begin
    mode_d = mode_q;
    led_d  = led;
    if (key_flag) begin
      mode_d = mode_after(mode_q);
      case (mode_d)
        MODE_FLOW_L: led_d = SEED_L;
        MODE_FLOW_R: led_d = SEED_R;
        MODE_BLINK:  led_d = SEED_ALL;
        default:     led_d = led;
      endcase
    end else if (tick_int) begin
      case (mode_q)
        MODE_FLOW_L: led_d = {led[LED_W-2:0], led[LED_W-1]};
        MODE_FLOW_R: led_d = {led[0], led[LED_W-1:1]};
        MODE_BLINK:  led_d = ~led;
        default:     led_d = led;
      endcase
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_led_flow_ctrl.sv
// Self-checking bench for led_flow_ctrl: window-based behavioural model plus directed literals.
module tb_led_flow_ctrl;

  localparam int DEB  = 8;
  localparam int TCYC = 4;

  logic       Clk50M = 1'b0;
  logic       Rst_n  = 1'b1;
  logic       tick   = 1'b0;
  logic       key_n  = 1'b1;
  logic [3:0] led;
  logic [1:0] mode;
  logic       key_flag;

  int n_checks = 0;
  int n_pass   = 0;
  int n_flags  = 0;

  always #10 Clk50M = ~Clk50M;

  led_flow_ctrl #(
    .DEBOUNCE_CYC(DEB),
    .TICK_CYC    (TCYC),
    .LED_W       (4)
  ) dut (
    .Clk50M  (Clk50M),
    .Rst_n   (Rst_n),
    .tick    (tick),
    .key_n   (key_n),
    .led     (led),
    .mode    (mode),
    .key_flag(key_flag)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: a press is accepted when the last DEB synchronised samples all
  // disagree with the accepted level; the flag follows one cycle later.
  int         m_mode      = 0;
  logic [3:0] m_led       = 4'b0001;
  logic       m_flag      = 1'b0;
  logic       m_fall_pend = 1'b0;
  logic       m_stable    = 1'b1;
  logic       hist [DEB+2];
  int         m_tcnt      = 0;

  initial foreach (hist[i]) hist[i] = 1'b1;

  always @(posedge Clk50M or negedge Rst_n) begin : model_step
    logic tick_eff;
    logic all_diff;
    if (!Rst_n) begin
      m_mode = 0; m_led = 4'b0001; m_flag = 1'b0; m_fall_pend = 1'b0;
      m_stable = 1'b1; m_tcnt = 0;
      foreach (hist[i]) hist[i] = 1'b1;
    end else begin
`ifdef INT_TICK_EN
      tick_eff = (m_tcnt == TCYC - 1);
      m_tcnt   = (m_tcnt + 1) % TCYC;
`else
      tick_eff = tick;
`endif
      if (m_flag) begin
        m_mode = (m_mode + 1) % 4;
        case (m_mode)
          0: m_led = 4'b0001;
          1: m_led = 4'b1000;
          2: m_led = 4'b1111;
          default: ;
        endcase
      end else if (tick_eff) begin
        case (m_mode)
          0: m_led = ((m_led << 1) | (m_led >> 3)) & 4'hF;
          1: m_led = ((m_led >> 1) | (m_led << 3)) & 4'hF;
          2: m_led = ~m_led;
          default: ;
        endcase
      end
      m_flag = m_fall_pend;
      // hist[0] is the newest raw sample; hist[1..DEB] are what the debouncer has seen.
      all_diff = 1'b1;
      for (int j = 1; j <= DEB; j++) if (hist[j] == m_stable) all_diff = 1'b0;
      m_fall_pend = 1'b0;
      if (all_diff) begin
        m_stable    = ~m_stable;
        m_fall_pend = ~m_stable;
      end
      for (int j = DEB + 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = key_n;
    end
  end

  always @(negedge Clk50M) begin
    check("led", led, m_led);
    check("mode", mode, m_mode);
    check("key_flag", key_flag, m_flag);
    if (key_flag) n_flags++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge Clk50M);
      #1;
    end
  endtask

  task automatic do_tick(input string nm, input logic [3:0] exp_led);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    check(nm, led, exp_led);
  endtask

  task automatic press();
    key_n = 1'b0;
    step(20);
    key_n = 1'b1;
    step(15);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int f0;
    int lat;
    logic [3:0] exp5 [5];
    logic [3:0] exp3 [3];
    exp5 = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    exp3 = '{4'b0000, 4'b1111, 4'b0000};

    #1 Rst_n = 1'b0;
    #30;
    check("reset_led", led, 4'b0001);
    check("reset_mode", mode, 0);
    check("reset_flag", key_flag, 0);
    @(negedge Clk50M);
    #1 Rst_n = 1'b1;

`ifdef INT_TICK_EN
    tick = 1'b0;
    step(3);
    check("int_tick_c3", led, 4'b0001);
    step(1);
    check("int_tick_c4", led, 4'b0010);
    step(4);
    check("int_tick_c8", led, 4'b0100);
    step(20);
`else
    foreach (exp5[i]) do_tick("flow_l_tick", exp5[i]);
    check("flow_l_mode", mode, 0);

    f0 = n_flags;
    lat = -1;
    key_n = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (key_flag && lat < 0) lat = i;
    end
    key_n = 1'b1;
    step(15);
    check("press_latency", lat, 2 + DEB + 1);
    check("press_one_flag", n_flags - f0, 1);
    check("press_mode", mode, 1);
    check("press_led", led, 4'b1000);
    do_tick("flow_r_tick1", 4'b0100);
    do_tick("flow_r_tick2", 4'b0010);

    f0 = n_flags;
    key_n = 1'b0;
    step(5);
    key_n = 1'b1;
    step(15);
    check("glitch_no_flag", n_flags - f0, 0);
    check("glitch_mode", mode, 1);
    check("glitch_led", led, 4'b0010);

    f0 = n_flags;
    repeat (3) begin
      key_n = 1'b0;
      step(3);
      key_n = 1'b1;
      step(3);
    end
    press();
    check("bounce_one_flag", n_flags - f0, 1);
    check("blink_mode", mode, 2);
    check("blink_led", led, 4'b1111);
    foreach (exp3[i]) do_tick("blink_tick", exp3[i]);

    press();
    check("hold_mode", mode, 3);
    check("hold_led", led, 4'b0000);
    repeat (4) do_tick("hold_tick", 4'b0000);

    press();
    check("wrap_mode", mode, 0);
    check("wrap_led", led, 4'b0001);
    do_tick("wrap_tick1", 4'b0010);
    do_tick("wrap_tick2", 4'b0100);

    key_n = 1'b0;
    step(2 + DEB + 1);
    check("same_cycle_flag", key_flag, 1);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    check("same_cycle_mode", mode, 1);
    check("same_cycle_led", led, 4'b1000);
    step(8);
    key_n = 1'b1;
    step(15);

    key_n = 1'b0;
    step(5);
    #5 Rst_n = 1'b0;
    #1;
    check("midreset_led", led, 4'b0001);
    check("midreset_mode", mode, 0);
    check("midreset_flag", key_flag, 0);
    key_n = 1'b1;
    step(2);
    Rst_n = 1'b1;
    f0 = n_flags;
    step(25);
    check("midreset_no_flag", n_flags - f0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
